present_ctr_out_buf: RTL

- Downstream consumer of the PRESENT CTR encryptor.
- Captures each 64-bit ciphertext block the encryptor produces once per 32-cycle encryption, buffers blocks in a small FIFO, and serialises them as bytes on a valid/ready stream.
- Absorbs consumer back-pressure and flags lost blocks.

---
 rtl/present_ctr_out_buf.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/present_ctr_out_buf.sv
// PRESENT CTR ciphertext capture FIFO and byte serialiser.
// Build option: PRESENT_OUT_LSB_FIRST_EN emits each block LSB-first.
module present_ctr_out_buf #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          clr,
  input  logic          load_encrypt,
  input  logic [63:0]   ciphertext,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [LW-1:0] level,
  output logic          overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [LW-1:0] r_level;
  logic          r_enc_q;
  logic          r_ovf;
  state_t        r_state;
  logic [63:0]   r_shreg;
  logic [2:0]    r_idx;
  logic          r_valid;
  logic          r_last;

  logic          w_full;
  logic          w_nempty;
  logic          w_xfer;
  logic          w_pop;
  logic          w_push;
  logic          w_wr;
  logic          w_drop;
  logic [63:0]   w_head;
  logic [63:0]   w_shift;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_nempty = (r_level != '0);
  assign w_xfer   = r_valid && out_ready;
  // A pop refills the output stage: from IDLE, or on the last byte
  assign w_pop    = w_nempty &&
                    ((r_state == IDLE) ||
                     (w_xfer && r_idx == 3'd7));
  assign w_push   = r_enc_q && arm;
  assign w_wr     = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;
  assign w_head   = r_mem[r_rp];

`ifdef PRESENT_OUT_LSB_FIRST_EN
  assign out_data = r_shreg[7:0];
  assign w_shift  = {8'h00, r_shreg[63:8]};
`else
  assign out_data = r_shreg[63:56];
  assign w_shift  = {r_shreg[55:0], 8'h00};
`endif

  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign level     = r_level;
  assign overflow  = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst && !clr && w_wr)
      r_mem[r_wp] <= ciphertext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_q <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_state <= IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_enc_q <= load_encrypt;
      if (clr) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_level <= '0;
        r_ovf   <= 1'b0;
        r_state <= IDLE;
        r_shreg <= '0;
        r_idx   <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        if (w_wr)
          r_wp <= r_wp + PW'(1);
        if (w_pop)
          r_rp <= r_rp + PW'(1);
        r_level <= r_level + LW'(w_wr) - LW'(w_pop);
        if (w_drop)
          r_ovf <= 1'b1;
        unique case (r_state)
          IDLE: begin
            if (w_pop) begin
              r_shreg <= w_head;
              r_idx   <= '0;
              r_valid <= 1'b1;
              r_last  <= 1'b0;
              r_state <= SEND;
            end
          end
          SEND: begin
            if (w_xfer) begin
              if (r_idx == 3'd7) begin
                if (w_pop) begin
                  r_shreg <= w_head;
                  r_idx   <= '0;
                  r_last  <= 1'b0;
                end else begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_state <= IDLE;
                end
              end else begin
                r_shreg <= w_shift;
                r_idx   <= r_idx + 3'd1;
                r_last  <= (r_idx == 3'd6);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
